// File: rtl/complete_arbiter_pkg.sv
// Shared types and defaults for the completion-lane arbiter.
// Optional statistics counters are enabled with COMPLETE_ARB_STATS_EN.
package complete_arbiter_pkg;

  localparam int DEF_N      = 3;
  localparam int DEF_NUM_FU = 6;
  localparam int ROB_IDX_W  = 6;
  localparam int ADDR_W     = 32;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 mispredict;
    logic                 branch_valid;
    logic                 branch_taken;
    logic [ADDR_W-1:0]    branch_target;
  } FU_RESULT_PACKET;

  // One completion lane of the EX/COMP register.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 mispredict;
    logic                 branch_valid;
    logic                 branch_taken;
    logic [ADDR_W-1:0]    branch_target;
  } EX_COMPLETE_PACKET;

endpackage

// File: rtl/complete_arbiter_if.sv
// FU-side request/grant handshake plus the registered lane outputs to stage_complete.
interface complete_arbiter_if
  import complete_arbiter_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int NUM_FU = DEF_NUM_FU
);
  logic              [NUM_FU-1:0] fu_valid;
  FU_RESULT_PACKET   [NUM_FU-1:0] fu_result;
  logic              [NUM_FU-1:0] fu_ready;
  logic              [N-1:0]      ex_valid_out;
  EX_COMPLETE_PACKET [N-1:0]      ex_comp_out;

  modport master (
    output fu_valid, fu_result,
    input  fu_ready, ex_valid_out, ex_comp_out
  );

  modport slave (
    input  fu_valid, fu_result,
    output fu_ready, ex_valid_out, ex_comp_out
  );
endinterface

// File: rtl/complete_arbiter_rr_select_n.sv
// Combinational N-of-M rotating-priority selector: grant vector, per-lane source index, grant count.
module rr_select_n #(
  parameter int N = 3,
  parameter int M = 6
) (
  input  logic [M-1:0]                    req,
  input  logic [$clog2(M)-1:0]            ptr,
  output logic [M-1:0]                    gnt,
  output logic [N-1:0][$clog2(M)-1:0]     src,
  output logic [$clog2(N+1)-1:0]          cnt
);
  localparam int PW = $clog2(M);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N+1);

  always_comb begin
    int g;
    int idx;
    gnt = '0;
    src = '0;
    g   = 0;
    idx = 0;
    // Walk the ring from ptr; the k-th hit fills lane k until all lanes are taken.
    for (int k = 0; k < M; k++) begin
      idx = int'(ptr) + k;
      if (idx >= M) idx = idx - M;
      if (req[PW'(idx)] && (g < N)) begin
        gnt[PW'(idx)] = 1'b1;
        src[SW'(g)]   = PW'(idx);
        g             = g + 1;
      end
    end
    cnt = CW'(g);
  end
endmodule

// File: rtl/complete_arbiter.sv
// Round-robin arbiter packing up to N FU results per cycle into the EX/COMP register.
// Define COMPLETE_ARB_STATS_EN to add grant / conflict-cycle counters.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int NUM_FU = DEF_NUM_FU
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  complete_arbiter_if.slave   bus
`ifdef COMPLETE_ARB_STATS_EN
  ,
  output logic [31:0]         stat_grants,
  output logic [31:0]         stat_conflict_cycles
`endif
);
  localparam int PW = $clog2(NUM_FU);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N+1);

  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            ptr_nxt;
  logic [NUM_FU-1:0]        gnt;
  logic [N-1:0][PW-1:0]     src;
  logic [CW-1:0]            cnt;
  logic [N-1:0]             vld_p0;
  EX_COMPLETE_PACKET [N-1:0] comp_p0;

  // Branch outcome fields are only meaningful when branch_valid is set.
  function automatic EX_COMPLETE_PACKET pack_lane(input FU_RESULT_PACKET r);
    EX_COMPLETE_PACKET e;
    e               = '0;
    e.rob_idx       = r.rob_idx;
    e.mispredict    = r.mispredict;
    e.branch_valid  = r.branch_valid;
    if (r.branch_valid) begin
      e.branch_taken  = r.branch_taken;
      e.branch_target = r.branch_target;
    end
    return e;
  endfunction

  rr_select_n #(.N(N), .M(NUM_FU)) u_sel (
    .req (bus.fu_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .src (src),
    .cnt (cnt)
  );

  assign bus.fu_ready = (reset || flush) ? '0 : gnt;

  // Stage p0: lane packing and next pointer (one past the last granted FU).
  always_comb begin
    vld_p0  = '0;
    comp_p0 = '0;
    ptr_nxt = rr_ptr;
    for (int k = 0; k < N; k++) begin
      if (k < int'(cnt)) begin
        vld_p0[LW'(k)]  = 1'b1;
        comp_p0[LW'(k)] = pack_lane(bus.fu_result[src[LW'(k)]]);
        ptr_nxt         = (int'(src[LW'(k)]) == NUM_FU-1) ? PW'(0) : src[LW'(k)] + 1'b1;
      end
    end
  end

  // Stage p1: EX/COMP register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.ex_valid_out <= '0;
      bus.ex_comp_out  <= '0;
      rr_ptr           <= '0;
    end else if (flush) begin
      bus.ex_valid_out <= '0;
      bus.ex_comp_out  <= '0;
    end else begin
      bus.ex_valid_out <= vld_p0;
      bus.ex_comp_out  <= comp_p0;
      rr_ptr           <= ptr_nxt;
    end
  end

`ifdef COMPLETE_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_grants          <= '0;
      stat_conflict_cycles <= '0;
    end else if (!flush) begin
      stat_grants <= stat_grants + 32'(cnt);
      if ($countones(bus.fu_valid) > N) stat_conflict_cycles <= stat_conflict_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed plus randomized bench for complete_arbiter against a queue-based round-robin model.
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  localparam int N      = DEF_N;
  localparam int NUM_FU = DEF_NUM_FU;
  localparam int PW     = $clog2(NUM_FU);
  localparam int LW     = (N > 1) ? $clog2(N) : 1;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  always #5 clock = ~clock;

  complete_arbiter_if #(.N(N), .NUM_FU(NUM_FU)) bus ();

`ifdef COMPLETE_ARB_STATS_EN
  logic [31:0] stat_grants;
  logic [31:0] stat_conflict_cycles;
  int unsigned m_grants;
  int unsigned m_conf;
`endif

  complete_arbiter #(.N(N), .NUM_FU(NUM_FU)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef COMPLETE_ARB_STATS_EN
    ,
    .stat_grants          (stat_grants),
    .stat_conflict_cycles (stat_conflict_cycles)
`endif
  );

  int compared   = 0;
  int mismatched = 0;
  int m_ptr      = 0;
  logic [NUM_FU-1:0] m_gnt;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic EX_COMPLETE_PACKET exp_lane(input FU_RESULT_PACKET r);
    EX_COMPLETE_PACKET e;
    e              = '0;
    e.rob_idx      = r.rob_idx;
    e.mispredict   = r.mispredict;
    e.branch_valid = r.branch_valid;
    e.branch_taken  = r.branch_valid ? r.branch_taken  : 1'b0;
    e.branch_target = r.branch_valid ? r.branch_target : '0;
    return e;
  endfunction

  function automatic FU_RESULT_PACKET rand_result();
    FU_RESULT_PACKET r;
    r.rob_idx       = ROB_IDX_W'($urandom);
    r.mispredict    = 1'($urandom);
    r.branch_valid  = 1'($urandom);
    r.branch_taken  = 1'($urandom);
    r.branch_target = ADDR_W'($urandom);
    return r;
  endfunction

  // One cycle: drive requests, check grants, then check the registered lanes.
  task automatic step(input logic [NUM_FU-1:0] v, input logic fl, input string tag);
    int order[$];
    logic [NUM_FU-1:0]        e_rdy;
    logic [N-1:0]             e_vld;
    EX_COMPLETE_PACKET [N-1:0] e_comp;
    bus.fu_valid = v;
    flush        = fl;
    e_rdy  = '0;
    e_vld  = '0;
    e_comp = '0;
    if (!fl) begin
      for (int k = 0; k < NUM_FU; k++) begin
        int i;
        i = (m_ptr + k) % NUM_FU;
        if (v[PW'(i)] && order.size() < N) order.push_back(i);
      end
      foreach (order[j]) begin
        e_rdy          = e_rdy | (NUM_FU'(1) << order[j]);
        e_vld          = e_vld | (N'(1) << j);
        e_comp[LW'(j)] = exp_lane(bus.fu_result[PW'(order[j])]);
      end
      if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % NUM_FU;
`ifdef COMPLETE_ARB_STATS_EN
      m_grants = m_grants + order.size();
      if ($countones(v) > N) m_conf = m_conf + 1;
`endif
    end
    m_gnt = e_rdy;
    #2;
    chk({tag, " ready"}, 256'(bus.fu_ready), 256'(e_rdy));
    @(posedge clock);
    #1;
    chk({tag, " valid"}, 256'(bus.ex_valid_out), 256'(e_vld));
    chk({tag, " comp"},  256'(bus.ex_comp_out),  256'(e_comp));
`ifdef COMPLETE_ARB_STATS_EN
    chk({tag, " stat_grants"},   256'(stat_grants),          256'(m_grants));
    chk({tag, " stat_conflict"}, 256'(stat_conflict_cycles), 256'(m_conf));
`endif
  endtask

  initial begin
    FU_RESULT_PACKET r;
    logic [NUM_FU-1:0] pend;

    reset        = 1'b1;
    flush        = 1'b0;
    bus.fu_valid = '1;
    for (int i = 0; i < NUM_FU; i++) begin
      r = rand_result();
      r.rob_idx = ROB_IDX_W'(10 + i);
      bus.fu_result[i] = r;
    end
`ifdef COMPLETE_ARB_STATS_EN
    m_grants = 0;
    m_conf   = 0;
`endif
    #12;
    chk("reset ready", 256'(bus.fu_ready), 256'(0));
    chk("reset valid", 256'(bus.ex_valid_out), 256'(0));
    chk("reset comp",  256'(bus.ex_comp_out), 256'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_ptr = 0;

    step(6'b000100, 1'b0, "single");
    chk("single lane0 rob", 256'(bus.ex_comp_out[0].rob_idx), 256'(12));
    step(6'b111111, 1'b0, "over1");
    step(6'b111111, 1'b0, "over2");
    step(6'b010000, 1'b0, "to_ptr5");
    step(6'b100011, 1'b0, "wrap");
    chk("wrap lane1 rob", 256'(bus.ex_comp_out[1].rob_idx), 256'(10));
    step(6'b111111, 1'b1, "flush");
    step(6'b000000, 1'b0, "idle");

    r = '0;
    r.rob_idx = 6'd7; r.mispredict = 1'b1; r.branch_valid = 1'b1;
    r.branch_taken = 1'b1; r.branch_target = 32'h1000;
    bus.fu_result[1] = r;
    step(6'b000010, 1'b0, "branch");
    chk("branch target", 256'(bus.ex_comp_out[0].branch_target), 256'(32'h1000));
    chk("branch taken",  256'(bus.ex_comp_out[0].branch_taken),  256'(1));
    chk("branch misp",   256'(bus.ex_comp_out[0].mispredict),    256'(1));
    r.branch_valid = 1'b0;
    bus.fu_result[1] = r;
    step(6'b000010, 1'b0, "nobranch");
    chk("nobranch target", 256'(bus.ex_comp_out[0].branch_target), 256'(0));
    chk("nobranch taken",  256'(bus.ex_comp_out[0].branch_taken),  256'(0));

    step(6'b111111, 1'b0, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    chk("async rst valid", 256'(bus.ex_valid_out), 256'(0));
    chk("async rst comp",  256'(bus.ex_comp_out),  256'(0));
    chk("async rst ready", 256'(bus.fu_ready),     256'(0));
    m_ptr = 0;
`ifdef COMPLETE_ARB_STATS_EN
    m_grants = 0;
    m_conf   = 0;
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.fu_valid = '1;
    #1;
    chk("post rst first grant", 256'(bus.fu_ready), 256'(6'b000111));
    step(6'b111111, 1'b0, "post_rst");

    pend = '0;
    for (int c = 0; c < 400; c++) begin
      logic fl;
      for (int i = 0; i < NUM_FU; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          bus.fu_result[i] = rand_result();
        end
      end
      fl = ($urandom_range(0, 9) == 0);
      step(pend, fl, "rand");
      if (fl) pend = '0;
      else    pend = pend & ~m_gnt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
